// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg
//   Shared types and width helpers for the MAC sequencer slice.
//   state_t    : controller states (IDLE, RUN, DRAIN)
//   cnt_width  : counter width for a modulus n. It never returns zero,
//                so a single-sum frame still gets a 1-bit index.
//   DEF_*      : default frame geometry used by mac_sequencer.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CYC  = 32;
  localparam int DEF_NUM_SUMS = 16;
  localparam int DEF_ACC_LAT  = 4;
  localparam int DEF_BW       = 16;

endpackage

// File: rtl/mac_sequencer_lat_tracker.sv
// lat_tracker
//   DEPTH-deep shift register of "last beat accepted" flags. A flag loaded
//   in cycle t appears on flag_out in cycle t+DEPTH, which is the cycle in
//   which the MAC output holds the finished sum. Several flags may be in
//   flight at once.
//   clk, reset : clock and synchronous active-high reset
//   flag_in    : last-beat flag for the current cycle
//   flag_out   : flag leaving the register (sum complete on MAC output)
module lat_tracker #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flag_in,
  output logic flag_out
);

  logic [DEPTH-1:0] pipe;

  // Written as a per-bit loop so that DEPTH=1 elaborates without an empty slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= flag_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign flag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Sequences one multiply-accumulate unit over a frame of NUM_SUMS dot
//   products of NUM_CYC beats each. It drives the MAC's new_sum, the
//   weight-ROM beat address and weight zeroing for bubble cycles. It also
//   captures every finished sum from the MAC into a registered output with
//   a one-cycle valid strobe.
//   clk, reset : clock, synchronous active-high reset
//   start      : begins a frame (only honoured in IDLE)
//   vld_in     : input beat valid; rdy_out says a beat is accepted this cycle
//   new_sum    : first beat of a sum is being accepted (to MAC)
//   w_addr     : weight-ROM beat index
//   w_zero     : forces MAC weights to zero (no beat accepted)
//   mac_data   : MAC accumulator output
//   vld_out    : one-cycle strobe, data_out/sum_idx hold a new result
//   data_out   : captured result
//   sum_idx    : index of the result on data_out within the frame
//   busy       : frame in progress (RUN or DRAIN)
//   done       : one-cycle pulse with the frame's final vld_out
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int NUM_CYC  = DEF_NUM_CYC,
  parameter int NUM_SUMS = DEF_NUM_SUMS,
  parameter int ACC_LAT  = DEF_ACC_LAT,
  parameter int BW       = DEF_BW,
  localparam int BEAT_W  = cnt_width(NUM_CYC),
  localparam int SUM_W   = cnt_width(NUM_SUMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vld_in,
  output logic              rdy_out,
  output logic              new_sum,
  output logic [BEAT_W-1:0] w_addr,
  output logic              w_zero,
  input  logic [BW-1:0]     mac_data,
  output logic              vld_out,
  output logic [BW-1:0]     data_out,
  output logic [SUM_W-1:0]  sum_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CYC - 1);
  localparam logic [SUM_W-1:0]  LAST_SUM  = SUM_W'(NUM_SUMS - 1);

  state_t            state;
  state_t            next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [SUM_W-1:0]  sum_cnt;
  logic [SUM_W-1:0]  res_cnt;
  logic              accept;
  logic              last_beat;
  logic              sum_ready;
  logic              final_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The MAC controls are purely combinational, so the weight ROM
  // (asynchronous read) and the data stream line up in the accept cycle.
  always_comb begin
    next_state    = state;
    rdy_out       = (state == RUN);
    busy          = (state != IDLE);
    accept        = vld_in & rdy_out;
    last_beat     = accept & (beat_cnt == LAST_BEAT);
    new_sum       = accept & (beat_cnt == '0);
    w_zero        = ~accept;
    final_capture = sum_ready & (res_cnt == LAST_SUM);
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_beat && (sum_cnt == LAST_SUM)) next_state = DRAIN;
      DRAIN:   if (final_capture) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign w_addr = beat_cnt;

  lat_tracker #(
    .DEPTH(ACC_LAT)
  ) u_lat_tracker (
    .clk     (clk),
    .reset   (reset),
    .flag_in (last_beat),
    .flag_out(sum_ready)
  );

  // The result counter is cleared on the final capture rather than left to
  // wrap, so non-power-of-two NUM_SUMS restart at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      sum_cnt  <= '0;
      res_cnt  <= '0;
      data_out <= '0;
      sum_idx  <= '0;
      vld_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_out <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          sum_cnt  <= sum_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (next_state == IDLE && state != IDLE) begin
        sum_cnt <= '0;
      end
      if (sum_ready) begin
        data_out <= mac_data;
        sum_idx  <= res_cnt;
        vld_out  <= 1'b1;
        done     <= final_capture;
        res_cnt  <= final_capture ? '0 : res_cnt + 1'b1;
      end
    end
  end

endmodule
